inorder_queue_ctrl: RTL

//  Sequencer and arbiter for the decode->OoO in-order instruction queue (IQ).
//  - Shares the single IQ enqueue port between NUM_REQ decode lanes (round-robin).
//  - Tracks IQ occupancy locally and issues dequeues while downstream dispatch credits remain.
//  - Runs the pipeline-flush sequence that clears the IQ.

---
 rtl/iq_ctrl_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/inorder_queue_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/iq_ctrl_pkg.sv
// iq_ctrl_pkg: shared FSM encodings and default widths for the in-order queue controller
package iq_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;
  localparam int ENTRY_W_DEF  = 302;
  localparam int IDX_BITS_DEF = 9;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant, search starts at ptr+1 mod N
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);
  logic found;
  int   idx;
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/inorder_queue_ctrl.sv
// inorder_queue_ctrl: IQ enqueue arbiter, credit-gated dequeue and flush sequencer.
// Optional perf counters enabled with IQ_CTRL_PERF_EN.
module inorder_queue_ctrl
  import iq_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ENTRY_W  = ENTRY_W_DEF,
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int CREDITS  = 16
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*ENTRY_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       q_write_o,
  output logic [ENTRY_W-1:0]         q_entry_o,
  output logic                       q_read_o,
  input  logic [ENTRY_W-1:0]         q_entry_i,
  output logic                       q_reset_o,
  output logic                       disp_valid_o,
  output logic [ENTRY_W-1:0]         disp_entry_o,
  input  logic                       credit_return_i,
  input  logic                       flush_i,
  output logic [IDX_BITS:0]          count_o,
  output logic                       busy_o,
  output logic                       credit_err_o
`ifdef IQ_CTRL_PERF_EN
  ,
  output logic [31:0]                perf_full_stall_o,
  output logic [31:0]                perf_credit_stall_o
`endif
);
  localparam int CREDIT_W = (CREDITS > 0) ? $clog2(CREDITS + 1) : 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_BITS:0] DEPTH_C = (IDX_BITS + 1)'(2 ** IDX_BITS);
  localparam logic [CREDIT_W-1:0] CREDITS_C = CREDIT_W'(CREDITS);
  state_e              state_q;
  logic [IDX_BITS:0]   count_q, count_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [PW-1:0]       rr_ptr_q, gnt_idx;
  logic                disp_valid_q, credit_err_q, run, wr_en, credit_ovf;
  logic [NUM_REQ-1:0]  grant;
  assign run   = (state_q == ST_RUN) && !flush_i;
  assign wr_en = run && (count_q < DEPTH_C);
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req   (req_valid_i),
    .ptr   (rr_ptr_q),
    .en    (wr_en),
    .grant (grant)
  );
  always_comb begin
    q_entry_o = '0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        q_entry_o = req_data_i[i*ENTRY_W +: ENTRY_W];
        gnt_idx   = PW'(i);
      end
  end
  assign req_ready_o = grant;
  assign q_write_o   = |(req_valid_i & grant);
  // A read alongside a write at count==1 would race the IQ empty flag
  assign q_read_o = run && (count_q != '0) && (credits_q != '0) &&
                    !((count_q == (IDX_BITS + 1)'(1)) && q_write_o);
  assign credit_ovf = credit_return_i && !q_read_o && (credits_q == CREDITS_C);
  assign credits_d  = credit_ovf ? credits_q
                    : credits_q - CREDIT_W'(q_read_o) + CREDIT_W'(credit_return_i);
  assign count_d    = (state_q == ST_FLUSH) ? '0
                    : count_q + (IDX_BITS + 1)'(q_write_o) - (IDX_BITS + 1)'(q_read_o);
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_RUN;
      count_q      <= '0;
      credits_q    <= CREDITS_C;
      rr_ptr_q     <= PW'(NUM_REQ - 1);
      disp_valid_q <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= (state_q == ST_RUN) ? (flush_i ? ST_FLUSH : ST_RUN)
                    : (state_q == ST_FLUSH) ? ST_RECOVER : ST_RUN;
      count_q      <= count_d;
      credits_q    <= credits_d;
      disp_valid_q <= q_read_o;
      if (q_write_o) rr_ptr_q <= gnt_idx;
      if (credit_ovf) credit_err_q <= 1'b1;
    end
  end
  assign q_reset_o    = state_q == ST_FLUSH;
  assign busy_o       = state_q != ST_RUN;
  assign disp_valid_o = disp_valid_q;
  assign disp_entry_o = q_entry_i;
  assign count_o      = count_q;
  assign credit_err_o = credit_err_q;
`ifdef IQ_CTRL_PERF_EN
  logic [31:0] perf_full_q, perf_credit_q;
  logic        full_stall, credit_stall;
  assign full_stall   = (|req_valid_i) && (count_q == DEPTH_C);
  assign credit_stall = (count_q != '0) && (credits_q == '0);
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_full_q   <= '0;
      perf_credit_q <= '0;
    end else begin
      perf_full_q   <= perf_full_q + 32'(full_stall && (perf_full_q != '1));
      perf_credit_q <= perf_credit_q + 32'(credit_stall && (perf_credit_q != '1));
    end
  end
  assign perf_full_stall_o   = perf_full_q;
  assign perf_credit_stall_o = perf_credit_q;
`endif
endmodule
